// File: rtl/rsa_job_scheduler.sv
// rtl/rsa_job_scheduler.sv - round-robin job scheduler sharing one RSA-256 core
// Buffers a 24-word job, bursts it into the core, returns the 8-word result tagged with requester id.
module rsa_job_scheduler #(
  parameter int NREQ    = 2,
  parameter int IDW     = 1,
  parameter int TIMEOUT = 65535,
  parameter int GAP     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  input  logic            in_valid,
  input  logic [31:0]     in_data,
  output logic            in_ready,
  output logic            res_valid,
  output logic [31:0]     res_data,
  output logic [IDW-1:0]  res_id,
  output logic            res_last,
  output logic            res_err,
  input  logic            res_ready,
  output logic            core_enable,
  output logic [31:0]     core_data,
  input  logic [31:0]     core_out,
  input  logic            core_flag,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, LOAD, START, FEED, WAIT, CAPT, RESP, GAPW} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr, winner, pick;
  logic           any_req;
  logic [4:0]     cnt;
  logic [2:0]     idx;
  logic [15:0]    tcnt, gcnt;
  logic           err;
  logic [31:0]    job_buf [24];
  logic [31:0]    res_buf [8];
  logic           last_word, timeout_hit, gap_done;

  assign last_word   = (cnt == 5'd23);
  assign timeout_hit = (tcnt == 16'(TIMEOUT - 1));
  assign gap_done    = (gcnt == 16'(GAP - 1));

  // First requesting index at or after ptr, wrapping.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_req && req[(int'(ptr) + i) % NREQ]) begin
        pick    = IDW'((int'(ptr) + i) % NREQ);
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    gnt         = '0;
    in_ready    = 1'b0;
    core_enable = 1'b0;
    core_data   = '0;
    res_valid   = 1'b0;
    res_data    = '0;
    res_id      = '0;
    res_last    = 1'b0;
    res_err     = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: if (any_req) state_nxt = LOAD;
      LOAD: begin
        gnt[winner] = 1'b1;
        in_ready    = 1'b1;
        if (in_valid && last_word) state_nxt = START;
      end
      START: begin
        core_enable = 1'b1;
        state_nxt   = FEED;
      end
      FEED: begin
        core_enable = 1'b1;
        core_data   = job_buf[cnt];
        if (last_word) state_nxt = WAIT;
      end
      WAIT: begin
        core_enable = 1'b1;
        if (core_flag)        state_nxt = CAPT;
        else if (timeout_hit) state_nxt = RESP;
      end
      CAPT: begin
        core_enable = 1'b1;
        if (idx == 3'd7) state_nxt = RESP;
      end
      RESP: begin
        res_valid = 1'b1;
        res_id    = winner;
        res_err   = err;
        res_last  = err || (idx == 3'd7);
        res_data  = err ? 32'd0 : res_buf[idx];
        if (res_ready && res_last) state_nxt = GAPW;
      end
      GAPW: if (gap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      winner <= '0;
      cnt    <= '0;
      idx    <= '0;
      tcnt   <= '0;
      gcnt   <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          winner <= pick;
          ptr    <= (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;
          cnt    <= '0;
          idx    <= '0;
          err    <= 1'b0;
        end
        LOAD:  if (in_valid) cnt <= last_word ? 5'd0 : cnt + 5'd1;
        START: cnt <= '0;
        FEED: begin
          cnt  <= last_word ? 5'd0 : cnt + 5'd1;
          tcnt <= '0;
        end
        WAIT: begin
          if (core_flag) idx <= 3'd1;
          else if (timeout_hit) begin
            err <= 1'b1;
            idx <= 3'd0;
          end else if (tcnt != 16'hFFFF) tcnt <= tcnt + 16'd1;
        end
        // idx wraps 7 -> 0 so RESP starts at word 0.
        CAPT: idx <= idx + 3'd1;
        RESP: begin
          gcnt <= '0;
          if (res_ready && !res_last) idx <= idx + 3'd1;
        end
        GAPW: if (gcnt != 16'hFFFF) gcnt <= gcnt + 16'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid)  job_buf[cnt] <= in_data;
    if (state == WAIT && core_flag) res_buf[0]   <= core_out;
    if (state == CAPT)              res_buf[idx] <= core_out;
  end

endmodule
